// File: rtl/three_bit_reg.sv
// Parallel-load register with synchronous active-low reset and load enable.
// Each bit is a plain flop behind a hold/load mux; the clock is never gated.
module three_bit_reg #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             CLK,
  input  logic [WIDTH-1:0] D,
  input  logic             Load,
  output logic [WIDTH-1:0] Q,
  input  logic             RST_N
);

  logic [WIDTH-1:0] r_q;

  // Reset wins over Load; with neither asserted the value is held.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_q <= '0;
    end else if (Load) begin
      r_q <= D;
    end
  end

  assign Q = r_q;

endmodule

// File: tb/tb_three_bit_reg.sv
// Scoreboard bench for three_bit_reg: expected Q is pushed at each edge
// and compared against the DUT on the following falling edge.
`timescale 1ns/100ps
module tb_three_bit_reg;

  localparam int unsigned WIDTH = 3;

  logic             CLK;
  logic [WIDTH-1:0] D;
  logic             Load;
  logic [WIDTH-1:0] Q;
  logic             RST_N;

  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] exp_q[$];
  int n_checks;
  int n_errors;

  three_bit_reg #(.WIDTH(WIDTH)) dut (
    .CLK  (CLK),
    .D    (D),
    .Load (Load),
    .Q    (Q),
    .RST_N(RST_N)
  );

  initial CLK = 1'b0;
  always #1 CLK = ~CLK;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: Q=%b expected %b at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge using the currently driven inputs, then compare.
  task automatic run_edge(input string tag);
    logic [WIDTH-1:0] e;
    @(posedge CLK);
    if (!RST_N)    m_q = '0;
    else if (Load) m_q = D;
    exp_q.push_back(m_q);
    @(negedge CLK);
    e = exp_q.pop_front();
    check(tag, Q, e);
  endtask

  task automatic drive(input logic [WIDTH-1:0] d, input logic ld,
                       input logic rst_n);
    D     = d;
    Load  = ld;
    RST_N = rst_n;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_q      = 'x;

    // Power-up: no reset, first load at the t=3 edge.
    drive(3'b101, 1'b0, 1'b1);
    @(negedge CLK);
    drive(3'b101, 1'b1, 1'b1);
    run_edge("load_101");
    drive(3'b101, 1'b0, 1'b1);
    run_edge("hold_101");
    // t=6: D changes after the load; Q keeps the captured value.
    drive(3'b010, 1'b0, 1'b1);
    check("d_change_ignored", Q, 3'b101);
    for (int i = 0; i < 4; i++) run_edge("hold_load0");

    // Synchronous reset asserted mid-cycle together with Load.
    drive(3'b111, 1'b1, 1'b1);
    run_edge("load_111");
    drive(3'b110, 1'b1, 1'b0);
    #0.5;
    check("rst_before_edge", Q, 3'b111);
    run_edge("rst_over_load");
    drive(3'b011, 1'b1, 1'b1);
    run_edge("release_load_011");

    // Back-to-back loads.
    drive(3'b001, 1'b1, 1'b1);
    run_edge("b2b_001");
    drive(3'b100, 1'b1, 1'b1);
    run_edge("b2b_100");
    drive(3'b010, 1'b1, 1'b1);
    run_edge("b2b_010");

    // D toggles every half period with Load low; Q must not move.
    Load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      D = WIDTH'(i * 5 + 3);
      @(posedge CLK);
      #0.5;
      check("toggle_mid_high", Q, m_q);
      D = ~D;
      @(negedge CLK);
      check("toggle_mid_low", Q, m_q);
    end

    // Randomised mix of reset, load and hold.
    for (int i = 0; i < 40; i++) begin
      drive(WIDTH'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) != 0));
      run_edge("random");
    end

    // Reset then hold: value stays cleared.
    drive(3'b111, 1'b0, 1'b0);
    run_edge("reset_state");
    drive(3'b111, 1'b0, 1'b1);
    run_edge("reset_hold");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/three_bit_reg.md
Name: three_bit_reg

Overview:
- 3-bit parallel-load register with load enable. It is a generic register-transfer building block: it holds a value until Load is asserted.
- Q is fully registered.
- Synchronous active-low reset clears the register.

Parameters:
- WIDTH, 3, data width of D and Q. Must be 3 for this block; present only for reuse.

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RST_N  input  1  synchronous active-low reset
- D  input  WIDTH  parallel data in
- Load  input  1  load enable, active-high
- Q  output  WIDTH  registered register contents

Behaviour:
- Port declaration order: CLK, D, Load, Q, RST_N. This keeps existing positional instantiations (CLK, D, Load, Q) valid.
- Single clock domain. Evaluation happens only at the rising edge of CLK.
- Rising edge with RST_N=0: Q <= 0 (3'b000). Reset has priority over Load.
- Rising edge with RST_N=1, Load=1: Q <= D, using the D value sampled at that edge.
- Rising edge with RST_N=1, Load=0: Q holds its previous value.
- Reset is synchronous. Asserting RST_N between edges does not change Q until the next rising edge.
- Latency: 1 clock. Q reflects a loaded D immediately after the capturing edge.
- D and Load changes between edges have no effect on Q. There is no combinational path from D or Load to Q.
- Power-up value is not guaranteed (X in simulation) until the first reset edge or load edge.
- Each bit is an independent D flip-flop with a 2:1 hold/load mux.
  - No gating of CLK.
  - Load acts as a data-path enable only.
- All WIDTH bits load together. There is no partial or per-bit load.
- Back-to-back loads on consecutive edges are allowed; each edge captures the current D.

Test Plan:
- Clock period 2 ns (toggle every 1 ns, first rising edge at t=1). RST_N=1. D=3'b101 at t=0, Load=1 at t=2, Load=0 at t=4, D=3'b010 at t=6 -> at t=6 Q=3'b101 (loaded at the t=3 edge; later D change ignored).
- After the above, hold Load=0 for several edges with D=3'b010 -> Q remains 3'b101.
- Q=3'b111 loaded. Drive RST_N=0 mid-cycle with Load=1, D=3'b110 -> Q stays 3'b111 until the next rising edge, then becomes 3'b000. Reset overrides Load.
- Release RST_N=1 with Load=1, D=3'b011 -> Q=3'b011 after one rising edge.
- Consecutive loads D=3'b001, 3'b100, 3'b010 on three successive edges with Load=1 -> Q follows 001, 100, 010, each one edge after D is presented.
- Toggle D every half-period with Load=0 -> Q unchanged, no glitches on Q.
